memory_unit: RTL and testbench
==============================

// Module: memory_unit
// PURPOSE
//  Data-memory (MEM) stage of the 16-bit pipelined core. It holds a word-addressed data RAM.
//  isst writes op2 to the address in aluresult; isld reads that address into ldresult.
//  Sits between the ALU/EX stage and writeback; ldresult feeds the writeback mux.
// PARAMETERS
//  DATA_W   16   data word width; equals the op2, aluresult and ldresult width
//  ADDR_W   8    address bits used; the RAM holds 2**ADDR_W words (default 256)
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  rst        in   1       synchronous, active-high reset
//  isld       in   1       load request for this cycle
//  isst       in   1       store request for this cycle
//  op2        in   DATA_W  store data
//  aluresult  in   DATA_W  effective word address from the ALU
//  ldresult   out  DATA_W  load data, registered
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high. Nothing is asynchronous.
//  - Address is aluresult[ADDR_W-1:0] and is word-addressed (no byte lanes).
//  - Upper aluresult bits are ignored, so addresses alias/wrap modulo 2**ADDR_W.
//  - rst=1 at a posedge: ldresult<=0 and every RAM word<=0. Reset overrides isld/isst.
//  - Store: isst=1 & isld=0 at a posedge -> mem[addr]<=op2. ldresult holds.
//  - Load: isld=1 & isst=0 at a posedge -> ldresult<=mem[addr].
//    Latency is 1 cycle: data is visible after the edge that sampled isld.
//  - Both isld and isst=1: the store wins, mem[addr]<=op2. ldresult holds; no load occurs.
//  - Neither asserted: RAM and ldresult both hold.
//  - Store then load at the same address on the next cycle returns the new data; no hazard.
//  - An unwritten location reads 0 after reset.
//  - X/Z on isld/isst is not supported; inputs are assumed clean at the edge.
//  - No stall, ready or valid handshake. Every request completes in a single cycle.
// STRUCTURE
//  - Shared package cpu_pkg: DATA_W=16, ADDR_W=8 and a data_t (logic [15:0]) typedef.
//  - One sub-module, dmem_ram: a synchronous single-port RAM.
//    Ports: clk, rst (clears all words), we, addr, wdata.
//    Combinational rdata; memory_unit registers rdata into ldresult.
//  - Top-level memory_unit: address truncation, the we/re decode with store priority,
//    and the ldresult register.
// TESTING
//  1. Reset for 2 cycles -> ldresult=16'h0000; load addr 0x0010 -> 16'h0000.
//  2. isst=1, aluresult=0x0001, op2=16'hA5A5 for one cycle.
//     Then isld=1, aluresult=0x0001 -> ldresult=16'hA5A5 one cycle later.
//  3. isld=1, aluresult=0x0002 (never written) -> ldresult=16'h0000.
//     Then isst=1, aluresult=0x0003, op2=16'h100A.
//     Then isld=1, aluresult=0x0003 -> 16'h100A.
//  4. Wrap: store 16'h5A5A at aluresult=0x0103, then load 0x0003 -> 16'h5A5A.
//  5. Simultaneous: with ldresult=16'h100A, drive isld=isst=1, aluresult=0x0004, op2=16'h101A.
//     -> ldresult stays 16'h100A. A following load of 0x0004 -> 16'h101A.
//  6. Reset mid-run after stores -> ldresult=0. A load of 0x0001 afterwards -> 16'h0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and data type for the 16-bit pipelined core.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/memory_unit_if.sv
// MEM-stage request/response bundle between EX and the data memory.
// Latency: n/a (wiring only); ldresult is driven by the registered load path.
// Backpressure: none; every request completes in the cycle it is presented.
interface memory_unit_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
);

    logic              isld;
    logic              isst;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] ldresult;

    // EX side: issues load/store requests, consumes load data.
    modport master (
        output isld,
        output isst,
        output op2,
        output aluresult,
        input  ldresult
    );

    // Memory side: accepts requests, returns load data.
    modport slave (
        input  isld,
        input  isst,
        input  op2,
        input  aluresult,
        output ldresult
    );

endinterface

// File: rtl/memory_unit_dmem_ram.sv
// Word-addressed single-port data RAM with synchronous clear of every word.
// Latency: write on the rising edge; read data is combinational from addr.
// Backpressure: none; one write per cycle is always accepted.
module dmem_ram
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: reset clears every word so unwritten locations read zero; otherwise write when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read port; the caller registers it, so a write is visible on the next cycle.
    assign rdata = mem[addr];

endmodule

// File: rtl/memory_unit.sv
// MEM stage: stores op2 at aluresult, loads aluresult into ldresult; store wins over load.
// Latency: store lands at the sampling edge; load data appears one edge after isld.
// Backpressure: none; no stall path, every request completes in a single cycle.
module memory_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    memory_unit_if.slave  bus
);

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] rdata;

    // Upper address bits are dropped on purpose: addresses wrap modulo the RAM depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.aluresult[DATA_W-1:ADDR_W];

    assign addr = bus.aluresult[ADDR_W-1:0];

    // A store always proceeds; a load is suppressed when a store shares the cycle.
    assign we = bus.isst;
    assign re = bus.isld & ~bus.isst;

    dmem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (bus.op2),
        .rdata (rdata)
    );

    // Load result register: cleared on reset, captures RAM data on a load, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ldresult <= '0;
        end else if (re) begin
            bus.ldresult <= rdata;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit.
// Latency: inputs change 1 time unit after a rising edge and results are sampled there too.
// Backpressure: n/a.
module tb_memory_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    memory_unit_if bus ();

    memory_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let a rising edge sample them, then settle past the edge.
    task automatic cyc(input logic r, input logic ld, input logic st,
                       input logic [15:0] a, input logic [15:0] d);
        rst           = r;
        bus.isld      = ld;
        bus.isst      = st;
        bus.aluresult = a;
        bus.op2       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (bus.ldresult === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, bus.ldresult, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.isld      = 1'b0;
        bus.isst      = 1'b0;
        bus.aluresult = '0;
        bus.op2       = '0;

        // 1. Reset for two cycles, then load an unwritten word.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("reset_ldresult", 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        check("load_0010_after_reset", 16'h0000);

        // 2. Store then load at address 1.
        cyc(1'b0, 1'b0, 1'b1, 16'h0001, 16'hA5A5);
        check("store_holds_ldresult", 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        check("load_0001", 16'hA5A5);

        // 3. Unwritten read, then store/load back-to-back at address 3.
        cyc(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000);
        check("load_0002_unwritten", 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 16'h0003, 16'h100A);
        check("store_0003_holds", 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        check("load_0003", 16'h100A);

        // Idle cycle with stray address/data: nothing changes.
        cyc(1'b0, 1'b0, 1'b0, 16'h0001, 16'hFFFF);
        check("idle_holds", 16'h100A);

        // 5. Simultaneous load+store: store wins, ldresult holds.
        cyc(1'b0, 1'b1, 1'b1, 16'h0004, 16'h101A);
        check("ld_st_both_holds", 16'h100A);
        cyc(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
        check("load_0004_after_both", 16'h101A);

        // 4. Address wrap: 0x0103 aliases 0x0003.
        cyc(1'b0, 1'b0, 1'b1, 16'h0103, 16'h5A5A);
        check("store_0103_holds", 16'h101A);
        cyc(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        check("load_0003_wrapped", 16'h5A5A);
        cyc(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        check("load_0001_intact", 16'hA5A5);
        cyc(1'b0, 1'b1, 1'b0, 16'hFF03, 16'h0000);
        check("load_ff03_alias", 16'h5A5A);

        // 6. Reset mid-run, with a store request that reset must override.
        cyc(1'b1, 1'b0, 1'b1, 16'h0006, 16'hFFFF);
        check("midrun_reset_ldresult", 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        check("load_0001_after_reset", 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 16'h0007, 16'h1234);
        cyc(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000);
        check("load_0007_after_reset", 16'h1234);
        cyc(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        check("load_0003_after_reset", 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000);
        check("reset_overrides_store", 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
        check("load_0004_after_reset", 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
